// File: rtl/hp_bar_animator.sv
// -----------------------------------------------------------------------------
// hp_bar_animator
//
// Owns the displayed HP value of one battle combatant and animates it toward
// a newly loaded target, one STEP per video frame. It also renders the HP bar
// for the palette stage: for every pixel it reports whether the pixel belongs
// to the bar (border included) and which colour it should take.
//
// Ports:
//   Clk               system clock
//   Reset             synchronous, active-high reset
//   frame_clk         raw VGA vsync level (asynchronous to Clk)
//   load              one-cycle pulse, capture target_hp as the new target
//   snap              qualifies load: jump straight to the target
//   target_hp[7:0]    requested HP target
//   max_hp[7:0]       combatant maximum HP
//   DrawX[9:0]        current pixel column
//   DrawY[9:0]        current pixel row
//   shown_hp[7:0]     displayed HP (registered)
//   busy              animation in progress (registered)
//   done              one-cycle pulse when the target has been reached
//   is_battleinfo_bar current pixel lies in the bar, border included
//   hp_r/hp_g/hp_b    pixel colour (combinational, zero latency)
// -----------------------------------------------------------------------------
module hp_bar_animator #(
    parameter logic [9:0] BAR_X = 10'd400,
    parameter logic [9:0] BAR_Y = 10'd300,
    parameter logic [6:0] BAR_W = 7'd100,
    parameter logic [3:0] BAR_H = 4'd6,
    parameter logic [7:0] STEP  = 8'd1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       load,
    input  logic       snap,
    input  logic [7:0] target_hp,
    input  logic [7:0] max_hp,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [7:0] shown_hp,
    output logic       busy,
    output logic       done,
    output logic       is_battleinfo_bar,
    output logic [7:0] hp_r,
    output logic [7:0] hp_g,
    output logic [7:0] hp_b
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DOWN   = 2'd1,
        ST_UP     = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Fill colour by health fraction: green above 1/2, yellow above 1/5,
    // red otherwise. Products are widened so 5*255 cannot wrap.
    function automatic logic [23:0] fill_colour(input logic [7:0] hp,
                                                input logic [7:0] mx);
        logic [8:0]  dbl;
        logic [10:0] five;
        logic [23:0] col;
        dbl  = {hp, 1'b0};
        five = {3'd0, hp} * 11'd5;
        if (dbl > {1'b0, mx}) begin
            col = 24'h38b818;
        end else if (five > {3'd0, mx}) begin
            col = 24'hf8d000;
        end else begin
            col = 24'hf83808;
        end
        return col;
    endfunction

    // -------------------------------------------------------------------------
    // Frame tick
    // -------------------------------------------------------------------------
    logic sync1_r;
    logic sync2_r;
    logic sync3_r;
    logic tick_s;

    // Two-flop synchroniser for vsync, plus a third flop for edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= frame_clk;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Falling edge of the synchronised level: entry into vertical sync.
    assign tick_s = sync3_r & ~sync2_r;

    // -------------------------------------------------------------------------
    // Animation FSM
    // -------------------------------------------------------------------------
    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] shown_r;
    logic [7:0] shown_next_s;
    logic [7:0] target_r;
    logic [7:0] target_next_s;
    logic       busy_r;
    logic       done_r;

    logic [7:0] clamped_s;
    logic [7:0] down_diff_s;
    logic [7:0] down_step_s;
    logic [8:0] up_sum_s;

    assign clamped_s   = (target_hp > max_hp) ? max_hp : target_hp;
    assign down_diff_s = shown_r - target_r;
    assign down_step_s = shown_r - STEP;
    // Nine bits so that shown + STEP near 255 cannot wrap around.
    assign up_sum_s    = {1'b0, shown_r} + {1'b0, STEP};

    // Next-state, next shown value and target capture.
    always_comb begin
        state_next_s  = state_r;
        shown_next_s  = shown_r;
        target_next_s = target_r;

        if (load) begin
            // A load wins over a coincident tick: that frame's step is skipped.
            target_next_s = clamped_s;
            if (snap) begin
                shown_next_s = clamped_s;
                state_next_s = ST_FINISH;
            end else if (clamped_s < shown_r) begin
                state_next_s = ST_DOWN;
            end else if (clamped_s > shown_r) begin
                state_next_s = ST_UP;
            end else begin
                state_next_s = ST_FINISH;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_DOWN: begin
                    if (tick_s) begin
                        if (down_diff_s > STEP) begin
                            shown_next_s = down_step_s;
                        end else begin
                            shown_next_s = target_r;
                            state_next_s = ST_FINISH;
                        end
                    end else begin
                        state_next_s = ST_DOWN;
                    end
                end
                ST_UP: begin
                    if (tick_s) begin
                        if (up_sum_s < {1'b0, target_r}) begin
                            shown_next_s = up_sum_s[7:0];
                        end else begin
                            shown_next_s = target_r;
                            state_next_s = ST_FINISH;
                        end
                    end else begin
                        state_next_s = ST_UP;
                    end
                end
                ST_FINISH: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end

        // A combatant with no maximum HP shows nothing; any running
        // animation is ended since its target is now zero as well.
        if (max_hp == 8'd0) begin
            shown_next_s  = 8'd0;
            target_next_s = 8'd0;
            if ((state_next_s == ST_DOWN) || (state_next_s == ST_UP)) begin
                state_next_s = ST_FINISH;
            end else begin
                state_next_s = state_next_s;
            end
        end else begin
            shown_next_s = shown_next_s;
        end
    end

    // State, displayed value, target and the registered busy/done flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            shown_r  <= 8'd0;
            target_r <= 8'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            shown_r  <= shown_next_s;
            target_r <= target_next_s;
            busy_r   <= (state_next_s == ST_DOWN) || (state_next_s == ST_UP);
            done_r   <= (state_next_s == ST_FINISH);
        end
    end

    assign shown_hp = shown_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // -------------------------------------------------------------------------
    // Pixel path
    // -------------------------------------------------------------------------
    logic [10:0] x_ext_s;
    logic [10:0] y_ext_s;
    logic [10:0] x_lo_s;
    logic [10:0] x_hi_s;
    logic [10:0] y_lo_s;
    logic [10:0] y_hi_s;
    logic        in_region_s;
    logic        on_border_s;
    logic [6:0]  col_s;
    logic [14:0] col_scaled_s;
    logic [14:0] hp_scaled_s;
    logic        filled_s;
    logic        pix_bar_s;
    logic [23:0] pix_rgb_s;

    // Eleven-bit coordinates keep BAR_X + BAR_W + 1 from overflowing.
    assign x_ext_s = {1'b0, DrawX};
    assign y_ext_s = {1'b0, DrawY};
    assign x_lo_s  = {1'b0, BAR_X};
    assign y_lo_s  = {1'b0, BAR_Y};
    assign x_hi_s  = x_lo_s + {4'd0, BAR_W} + 11'd1;
    assign y_hi_s  = y_lo_s + {7'd0, BAR_H} + 11'd1;

    assign in_region_s = (x_ext_s >= x_lo_s) && (x_ext_s <= x_hi_s) &&
                         (y_ext_s >= y_lo_s) && (y_ext_s <= y_hi_s);
    assign on_border_s = (x_ext_s == x_lo_s) || (x_ext_s == x_hi_s) ||
                         (y_ext_s == y_lo_s) || (y_ext_s == y_hi_s);

    // Interior column index; only meaningful inside the border, where it
    // never exceeds BAR_W - 1, so seven bits of modular arithmetic suffice.
    assign col_s        = DrawX[6:0] - BAR_X[6:0] - 7'd1;
    // Filled iff col/BAR_W < shown/max, cross-multiplied to avoid division.
    assign col_scaled_s = {8'd0, col_s} * {7'd0, max_hp};
    assign hp_scaled_s  = {7'd0, shown_r} * {8'd0, BAR_W};
    assign filled_s     = col_scaled_s < hp_scaled_s;

    // Per-pixel bar membership and colour.
    always_comb begin
        pix_bar_s = 1'b0;
        pix_rgb_s = 24'h000000;
        if (in_region_s) begin
            pix_bar_s = 1'b1;
            if (on_border_s) begin
                pix_rgb_s = 24'h000000;
            end else if (filled_s) begin
                pix_rgb_s = fill_colour(shown_r, max_hp);
            end else begin
                pix_rgb_s = 24'hd9d9d9;
            end
        end else begin
            pix_bar_s = 1'b0;
            pix_rgb_s = 24'h000000;
        end
    end

    assign is_battleinfo_bar = pix_bar_s;
    assign hp_r              = pix_rgb_s[23:16];
    assign hp_g              = pix_rgb_s[15:8];
    assign hp_b              = pix_rgb_s[7:0];

endmodule

// File: doc/hp_bar_animator.md
Name: hp_bar_animator

Overview:
Upstream of the colour palette stage. Owns the displayed HP value for one battle combatant. On each frame it steps that value toward a newly loaded target, producing the draining or filling bar animation. Per pixel, it drives is_battleinfo_bar and the hp_r/hp_g/hp_b colour that the palette outputs directly. One instance is built per combatant.

Parameters:
BAR_X, 10'd400, left pixel column of the bar border
BAR_Y, 10'd300, top pixel row of the bar border
BAR_W, 7'd100, interior width in pixels (1..127)
BAR_H, 4'd6, interior height in pixels (1..15)
STEP, 8'd1, HP units moved per frame tick

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  raw VGA vertical-sync level, asynchronous to the animation
load  in  1  single-cycle pulse; capture target_hp as the new animation target
snap  in  1  valid with load; jump shown_hp straight to the target with no animation
target_hp  in  8  new HP target
max_hp  in  8  combatant maximum HP
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
shown_hp  out  8  currently displayed HP (registered)
busy  out  1  high while an animation is in progress (registered)
done  out  1  single-cycle pulse when shown_hp reaches the target
is_battleinfo_bar  out  1  current pixel lies in the bar, border included
hp_r  out  8  pixel red
hp_g  out  8  pixel green
hp_b  out  8  pixel blue

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - shown_hp = 0, target register = 0, state = IDLE.
  - busy = 0, done = 0.
  - frame_clk synchroniser flops = 0.
  - Reset asserted mid-animation abandons the animation on the next edge.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then a third flop.
  - tick = one-cycle pulse on a synchronised falling edge, i.e. entry into vsync.
  - Exactly one tick per frame.
- Target clamp: the captured target is min(target_hp, max_hp).
- FSM states: IDLE, DOWN, UP, FINISH.
  - IDLE, load & snap: shown_hp <= clamped target; go to FINISH.
  - IDLE, load & !snap: go to DOWN if clamped target < shown_hp, UP if greater, FINISH if equal.
  - DOWN, on tick: shown_hp <= (shown_hp - target > STEP) ? shown_hp - STEP : target. Go to FINISH when target is reached.
  - UP, on tick: symmetric to DOWN. Compute at 9 bits so 255 + STEP cannot wrap.
  - FINISH: done = 1 for exactly one cycle; busy = 0; return to IDLE.
- busy = 1 in DOWN and UP only.
- load during DOWN/UP:
  - The target is re-captured and the direction re-evaluated in the same cycle.
  - The state may flip DOWN<->UP, or go to FINISH if the new target equals shown_hp.
  - No tick is consumed by the re-capture.
- load and tick in the same cycle: load takes priority; the step is skipped for that frame.
- load while in FINISH: handled as from IDLE; done still pulses.
- max_hp = 0: shown_hp forced to 0 on the next edge; the bar interior is drawn entirely empty.
- Pixel path (combinational from DrawX/DrawY and registered shown_hp; zero latency, so it aligns with the palette):
  - Region: DrawX in [BAR_X, BAR_X+BAR_W+1], DrawY in [BAR_Y, BAR_Y+BAR_H+1].
  - Border ring, 1 px: colour 00/00/00.
  - Interior column c = DrawX - BAR_X - 1.
  - Filled iff c*max_hp < shown_hp*BAR_W, using a 15-bit compare.
  - Filled colour:
    - green 38/b8/18 if 2*shown_hp > max_hp;
    - else yellow f8/d0/00 if 5*shown_hp > max_hp;
    - else red f8/38/08.
  - Empty interior: d9/d9/d9.
  - Outside the region: is_battleinfo_bar = 0, colour = 00/00/00.

Test Plan:
- Reset, then max_hp=100, load snap target=100 -> shown_hp=100 one cycle after load, done pulses once, busy never rises; pixel (BAR_X+50, BAR_Y+3) green 38/b8/18.
- From 100, load target=40, STEP=1 -> busy high; shown_hp 99, 98, ... one per tick; done after exactly 60 ticks; colour turns yellow when shown_hp=50, red at 20 if retargeted lower.
- Mid-drain at shown_hp=70, load target=90 -> state UP; shown_hp 71 on the next tick; done when 90 is reached; no extra tick consumed.
- load target=200 with max_hp=150 -> target clamped to 150; shown_hp stops at 150.
- Reset asserted while in DOWN at shown_hp=55 -> next cycle shown_hp=0, busy=0, done=0; later ticks leave shown_hp unchanged.
- Pixel scan with shown_hp=0, max_hp=100 -> border pixels black, all interior pixels d9/d9/d9, pixel (BAR_X-1, BAR_Y) has is_battleinfo_bar=0.
